fifo_sync_cfg: RTL and testbench
================================

FIFO_SYNC_CFG -- requirements
Module: fifo_sync_cfg

Interface
REQ-001 Parameter ADDR_W, default 10, RAM address width; RAM depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter WORDS_TOTAL, default 2**ADDR_W, usable capacity, 1..2**ADDR_W.
REQ-004 Parameter FWFT, default 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
REQ-005 Parameter AFULL_LVL, default WORDS_TOTAL-1, almost-full threshold.
REQ-006 Parameter AEMPTY_LVL, default 1, almost-empty threshold.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 flush  in  1  synchronous content clear.
REQ-010 err_clr  in  1  clears sticky error flags.
REQ-011 wdata  in  DATA_W  write data.
REQ-012 wen  in  1  write request.
REQ-013 full / afull  out  1 each  capacity flags.
REQ-014 ren  in  1  read request (standard) / pop (FWFT).
REQ-015 rdata  out  DATA_W  read data.
REQ-016 rvalid  out  1  rdata qualifier.
REQ-017 empty / aempty  out  1 each  occupancy flags.
REQ-018 load  out  ADDR_W+1  current word count.
REQ-019 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-020 load SHALL equal accepted writes minus accepted reads, including any word held in the FWFT output stage; range 0..WORDS_TOTAL.
REQ-021 full = (load == WORDS_TOTAL); empty = (load == 0); afull = (load >= AFULL_LVL); aempty = (load <= AEMPTY_LVL); all derived from registered load.
REQ-022 Write accepted iff wen & ~full & ~flush; accepted word stored at write pointer, pointer +1 modulo WORDS_TOTAL.
REQ-023 Write while full SHALL be rejected (even with concurrent accepted read) and SHALL set overflow.
REQ-024 Standard mode: read accepted iff ren & ~empty & ~flush; rdata holds that word and rvalid=1 in the next cycle only; rdata holds its last value otherwise.
REQ-025 FWFT mode: rvalid=1 whenever the head word is presented on rdata; read accepted iff ren & rvalid & ~flush; next word (if any) SHALL be presented in the following cycle with no rvalid gap.
REQ-026 FWFT mode: write accepted in cycle T into a FIFO with load==0 SHALL give rvalid=1 with that word on rdata in cycle T+2.
REQ-027 Read request not accepted (standard: ren & empty; FWFT: ren & ~rvalid), flush low, SHALL set underflow.
REQ-028 Simultaneous accepted write and read SHALL leave load unchanged; when load==0, write accepted and read rejected.
REQ-029 Pointers SHALL wrap to 0 after WORDS_TOTAL-1, including WORDS_TOTAL < 2**ADDR_W.
REQ-030 flush=1 SHALL zero pointers, load, rvalid in the next cycle; wen/ren that cycle ignored, no error flag set; overflow/underflow unchanged.
REQ-031 overflow/underflow remain set until err_clr or rst; a set event coincident with err_clr SHALL win.
REQ-032 Data order SHALL be strictly first-in first-out in both modes.

Reset
REQ-033 rst SHALL take priority over all inputs; next cycle: load=0, empty=1, full=0, aempty=1, afull=0 (AFULL_LVL>0), rvalid=0, overflow=0, underflow=0, pointers 0.
REQ-034 rdata value after reset unspecified until first rvalid.
REQ-035 rst asserted mid-transfer SHALL discard all stored words and any pending rvalid.

Verification
REQ-036 Std, ADDR_W=2: write 0x11,0x22,0x33,0x44 -> full=1, load=4; 5th wen -> rejected, overflow=1; 4 reads -> rdata 0x11..0x44 each one cycle after ren, empty=1.
REQ-037 FWFT: single write 0xA5 at cycle T into empty FIFO -> rvalid=1, rdata=0xA5 at T+2; ren pop -> rvalid=0 next cycle, load=0.
REQ-038 Std, empty: ren & wen same cycle -> write taken, underflow=1, load=1; err_clr -> underflow=0.
REQ-039 WORDS_TOTAL=3, ADDR_W=2: 10 write/read pairs with continuous streaming -> data in order across wrap, load never exceeds 3.
REQ-040 Load 3 words, flush with wen and ren high -> next cycle load=0, empty=1, rvalid=0, no error flags set.
REQ-041 AFULL_LVL=3, AEMPTY_LVL=1: fill 0->4 -> aempty high at load 0..1, afull high at load 3..4; rst mid-fill -> all outputs to REQ-033 values.

Source files
------------

// File: rtl/fifo_sync_cfg.sv
// Synchronous single-clock FIFO with a configurable usable depth, standard
// (registered read) or first-word-fall-through read mode, almost-full /
// almost-empty thresholds, a synchronous flush and sticky overflow/underflow
// error flags.
module fifo_sync_cfg #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int WORDS_TOTAL = 2**ADDR_W,
  parameter int FWFT        = 0,
  parameter int AFULL_LVL   = WORDS_TOTAL-1,
  parameter int AEMPTY_LVL  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  output logic              full,
  output logic              afull,
  input  logic              ren,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              empty,
  output logic              aempty,
  output logic [ADDR_W:0]   load,
  output logic              overflow,
  output logic              underflow
);

  localparam int                DEPTH      = 2**ADDR_W;
  localparam bit                IS_FWFT    = (FWFT != 0);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(WORDS_TOTAL-1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LOAD_MAX   = (ADDR_W+1)'(WORDS_TOTAL);
  localparam logic [ADDR_W:0]   LOAD_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   AFULL_CMP  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   AEMPTY_CMP = (ADDR_W+1)'(AEMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   load_q, load_d;
  logic              rvalid_q, rvalid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              wr_acc;      // write stored this cycle
  logic              std_rd;      // standard-mode read accepted
  logic              pop;         // FWFT head word consumed
  logic              fetch;       // FWFT output stage refilled from RAM
  logic              rd_acc;      // word leaves the occupancy count
  logic              ram_rd;      // RAM read port fires, read pointer advances
  logic [ADDR_W:0]   ram_cnt;     // words still in RAM (excludes FWFT output stage)
  logic              ovf_set;
  logic              unf_set;

  // Pointers wrap at the usable capacity, which may be below the RAM depth.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // Status flags, all decoded from the registered occupancy count.
  always_comb begin
    full      = (load_q == LOAD_MAX);
    empty     = (load_q == '0);
    afull     = (load_q >= AFULL_CMP);
    aempty    = (load_q <= AEMPTY_CMP);
    load      = load_q;
    rvalid    = rvalid_q;
    rdata     = rdata_q;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  // Accept/reject decisions for this cycle in both read modes.
  always_comb begin
    wr_acc  = wen & ~full & ~flush;
    std_rd  = ren & ~empty & ~flush;
    pop     = ren & rvalid_q & ~flush;
    ram_cnt = load_q - {{ADDR_W{1'b0}}, rvalid_q};
    fetch   = (~rvalid_q | pop) & (ram_cnt != '0) & ~flush;
    rd_acc  = IS_FWFT ? pop   : std_rd;
    ram_rd  = IS_FWFT ? fetch : std_rd;
    ovf_set = wen & full & ~flush;
    unf_set = IS_FWFT ? (ren & ~rvalid_q & ~flush) : (ren & empty & ~flush);
  end

  // Next-state logic for pointers, count, output stage and error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    load_d      = load_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    // A set event in the same cycle as err_clr keeps the flag set.
    overflow_d  = (overflow_q  & ~err_clr) | ovf_set;
    underflow_d = (underflow_q & ~err_clr) | unf_set;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      load_d   = '0;
      rvalid_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (ram_rd) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        rdata_d  = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   load_d = load_q + LOAD_ONE;
        2'b01:   load_d = load_q - LOAD_ONE;
        default: load_d = load_q;
      endcase
      if (IS_FWFT) rvalid_d = ram_rd | (rvalid_q & ~pop);
      else         rvalid_d = ram_rd;
    end
  end

  // Control state register; synchronous reset overrides every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      load_q      <= '0;
      rvalid_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      load_q      <= load_d;
      rvalid_q    <= rvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array and read data register.
  always_ff @(posedge clk) begin
    // NOTE: the RAM and rdata are deliberately not reset; resetting pointers
    // and count discards the contents, and leaving the array reset-free lets
    // it map onto block RAM.
    if (wr_acc && !rst) mem[wr_ptr_q] <= wdata;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Directed bench for fifo_sync_cfg: three instances (standard 4-deep,
// FWFT 4-deep, standard 3-of-4-deep) share stimulus; each task checks the
// instance it targets against hand-derived values.
module tb_fifo_sync_cfg;

  logic       clk = 1'b0;
  logic       rst, flush, err_clr, wen, ren;
  logic [7:0] wdata;

  logic       s_full, s_afull, s_rvalid, s_empty, s_aempty, s_overflow, s_underflow;
  logic [7:0] s_rdata;
  logic [2:0] s_load;
  logic       f_full, f_afull, f_rvalid, f_empty, f_aempty, f_overflow, f_underflow;
  logic [7:0] f_rdata;
  logic [2:0] f_load;
  logic       w_full, w_afull, w_rvalid, w_empty, w_aempty, w_overflow, w_underflow;
  logic [7:0] w_rdata;
  logic [2:0] w_load;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_sync_cfg #(.ADDR_W(2), .DATA_W(8)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .wdata(wdata), .wen(wen),
    .full(s_full), .afull(s_afull), .ren(ren), .rdata(s_rdata), .rvalid(s_rvalid),
    .empty(s_empty), .aempty(s_aempty), .load(s_load), .overflow(s_overflow),
    .underflow(s_underflow));

  fifo_sync_cfg #(.ADDR_W(2), .DATA_W(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .wdata(wdata), .wen(wen),
    .full(f_full), .afull(f_afull), .ren(ren), .rdata(f_rdata), .rvalid(f_rvalid),
    .empty(f_empty), .aempty(f_aempty), .load(f_load), .overflow(f_overflow),
    .underflow(f_underflow));

  fifo_sync_cfg #(.ADDR_W(2), .DATA_W(8), .WORDS_TOTAL(3)) u_w3 (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr), .wdata(wdata), .wen(wen),
    .full(w_full), .afull(w_afull), .ren(ren), .rdata(w_rdata), .rvalid(w_rvalid),
    .empty(w_empty), .aempty(w_aempty), .load(w_load), .overflow(w_overflow),
    .underflow(w_underflow));

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (s_load !== 3'd0)     begin n_err++; $display("FAIL rst_load: got %0d exp 0", s_load); end
    n_vec++; if (s_empty !== 1'b1)    begin n_err++; $display("FAIL rst_empty: got %b exp 1", s_empty); end
    n_vec++; if (s_full !== 1'b0)     begin n_err++; $display("FAIL rst_full: got %b exp 0", s_full); end
    n_vec++; if (s_aempty !== 1'b1)   begin n_err++; $display("FAIL rst_aempty: got %b exp 1", s_aempty); end
    n_vec++; if (s_afull !== 1'b0)    begin n_err++; $display("FAIL rst_afull: got %b exp 0", s_afull); end
    n_vec++; if (s_rvalid !== 1'b0)   begin n_err++; $display("FAIL rst_rvalid: got %b exp 0", s_rvalid); end
    n_vec++; if (s_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", s_overflow); end
    n_vec++; if (s_underflow !== 1'b0) begin n_err++; $display("FAIL rst_unf: got %b exp 0", s_underflow); end
    n_vec++; if (f_rvalid !== 1'b0)   begin n_err++; $display("FAIL rst_fwft_rvalid: got %b exp 0", f_rvalid); end
  endtask

  task automatic test_std_fill_drain();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wen = 1'b1; wdata = exp_d[i]; tick();
    end
    wen = 1'b0;
    n_vec++; if (s_full !== 1'b1)  begin n_err++; $display("FAIL std_full: got %b exp 1", s_full); end
    n_vec++; if (s_load !== 3'd4)  begin n_err++; $display("FAIL std_load4: got %0d exp 4", s_load); end
    wen = 1'b1; wdata = 8'h55; tick(); wen = 1'b0;
    n_vec++; if (s_overflow !== 1'b1) begin n_err++; $display("FAIL std_ovf: got %b exp 1", s_overflow); end
    n_vec++; if (s_load !== 3'd4)  begin n_err++; $display("FAIL std_ovf_load: got %0d exp 4", s_load); end
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1; tick();
      n_vec++;
      if (s_rvalid !== 1'b1 || s_rdata !== exp_d[i]) begin
        n_err++; $display("FAIL std_read%0d: got v=%b d=%h exp v=1 d=%h", i, s_rvalid, s_rdata, exp_d[i]);
      end
    end
    ren = 1'b0; tick();
    n_vec++; if (s_empty !== 1'b1)  begin n_err++; $display("FAIL std_empty: got %b exp 1", s_empty); end
    n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL std_rvalid_drop: got %b exp 0", s_rvalid); end
    n_vec++; if (s_rdata !== 8'h44) begin n_err++; $display("FAIL std_rdata_hold: got %h exp 44", s_rdata); end
  endtask

  task automatic test_std_underflow();
    do_reset();
    ren = 1'b1; wen = 1'b1; wdata = 8'h5A; tick(); ren = 1'b0; wen = 1'b0;
    n_vec++; if (s_underflow !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b exp 1", s_underflow); end
    n_vec++; if (s_load !== 3'd1)      begin n_err++; $display("FAIL unf_load: got %0d exp 1", s_load); end
    n_vec++; if (s_rvalid !== 1'b0)    begin n_err++; $display("FAIL unf_rvalid: got %b exp 0", s_rvalid); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_vec++; if (s_underflow !== 1'b0) begin n_err++; $display("FAIL unf_clr: got %b exp 0", s_underflow); end
    ren = 1'b1; tick();
    n_vec++; if (s_rdata !== 8'h5A)    begin n_err++; $display("FAIL unf_data: got %h exp 5a", s_rdata); end
    err_clr = 1'b1; tick(); ren = 1'b0; err_clr = 1'b0;
    n_vec++; if (s_underflow !== 1'b1) begin n_err++; $display("FAIL unf_set_wins: got %b exp 1", s_underflow); end
  endtask

  task automatic test_fwft();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    do_reset();
    wen = 1'b1; wdata = 8'hA5; tick(); wen = 1'b0;
    n_vec++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL fwft_t1_rvalid: got %b exp 0", f_rvalid); end
    tick();
    n_vec++;
    if (f_rvalid !== 1'b1 || f_rdata !== 8'hA5) begin
      n_err++; $display("FAIL fwft_t2: got v=%b d=%h exp v=1 d=a5", f_rvalid, f_rdata);
    end
    n_vec++; if (f_load !== 3'd1)   begin n_err++; $display("FAIL fwft_load1: got %0d exp 1", f_load); end
    ren = 1'b1; tick(); ren = 1'b0;
    n_vec++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL fwft_pop_rvalid: got %b exp 0", f_rvalid); end
    n_vec++; if (f_load !== 3'd0)   begin n_err++; $display("FAIL fwft_pop_load: got %0d exp 0", f_load); end
    // Back-to-back pops must present the next word with no rvalid gap.
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wdata = exp_d[i]; tick();
    end
    wen = 1'b0;
    n_vec++; if (f_load !== 3'd3)   begin n_err++; $display("FAIL fwft_load3: got %0d exp 3", f_load); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (f_rvalid !== 1'b1 || f_rdata !== exp_d[i]) begin
        n_err++; $display("FAIL fwft_b2b%0d: got v=%b d=%h exp v=1 d=%h", i, f_rvalid, f_rdata, exp_d[i]);
      end
      ren = 1'b1; tick();
    end
    ren = 1'b0;
    n_vec++; if (f_rvalid !== 1'b0) begin n_err++; $display("FAIL fwft_drained: got %b exp 0", f_rvalid); end
    n_vec++; if (f_underflow !== 1'b0) begin n_err++; $display("FAIL fwft_no_unf: got %b exp 0", f_underflow); end
    ren = 1'b1; tick(); ren = 1'b0;
    n_vec++; if (f_underflow !== 1'b1) begin n_err++; $display("FAIL fwft_unf: got %b exp 1", f_underflow); end
  endtask

  task automatic test_wrap_w3();
    logic [7:0] d;
    logic [2:0] exp_load;
    do_reset();
    // Two writes prime the FIFO, eight write+read pairs stream, two reads drain.
    for (int c = 0; c < 12; c++) begin
      wen = (c < 10); ren = (c >= 2); d = 8'h30 + 8'(c); wdata = d;
      tick();
      exp_load = (c < 2) ? 3'(c + 1) : (c < 10) ? 3'd2 : 3'(11 - c);
      n_vec++; if (w_load !== exp_load) begin n_err++; $display("FAIL wrap_load%0d: got %0d exp %0d", c, w_load, exp_load); end
      if (c >= 2) begin
        d = 8'h30 + 8'(c - 2);
        n_vec++;
        if (w_rvalid !== 1'b1 || w_rdata !== d) begin
          n_err++; $display("FAIL wrap_data%0d: got v=%b d=%h exp v=1 d=%h", c, w_rvalid, w_rdata, d);
        end
      end
    end
    wen = 1'b0; ren = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wdata = 8'hA0 + 8'(i); tick();
    end
    wen = 1'b0;
    n_vec++; if (w_full !== 1'b1 || w_load !== 3'd3) begin n_err++; $display("FAIL w3_full: got f=%b l=%0d exp f=1 l=3", w_full, w_load); end
    // Write while full is rejected even with a concurrent accepted read.
    wen = 1'b1; ren = 1'b1; wdata = 8'hEE; tick(); wen = 1'b0;
    n_vec++; if (w_load !== 3'd2)     begin n_err++; $display("FAIL w3_rej_load: got %0d exp 2", w_load); end
    n_vec++; if (w_overflow !== 1'b1) begin n_err++; $display("FAIL w3_ovf: got %b exp 1", w_overflow); end
    n_vec++; if (w_rdata !== 8'hA0)   begin n_err++; $display("FAIL w3_rd0: got %h exp a0", w_rdata); end
    tick();
    n_vec++; if (w_rdata !== 8'hA1)   begin n_err++; $display("FAIL w3_rd1: got %h exp a1", w_rdata); end
    tick(); ren = 1'b0;
    n_vec++; if (w_rdata !== 8'hA2)   begin n_err++; $display("FAIL w3_rd2: got %h exp a2", w_rdata); end
    n_vec++; if (w_empty !== 1'b1)    begin n_err++; $display("FAIL w3_empty: got %b exp 1", w_empty); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wen = 1'b1; wdata = 8'hC0 + 8'(i); tick();
    end
    flush = 1'b1; wen = 1'b1; ren = 1'b1; wdata = 8'hFF; tick();
    flush = 1'b0; wen = 1'b0; ren = 1'b0;
    n_vec++; if (s_load !== 3'd0 || s_empty !== 1'b1) begin n_err++; $display("FAIL flush_load: got l=%0d e=%b exp l=0 e=1", s_load, s_empty); end
    n_vec++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL flush_rvalid: got %b exp 0", s_rvalid); end
    n_vec++; if (s_overflow !== 1'b0 || s_underflow !== 1'b0) begin n_err++; $display("FAIL flush_err: got o=%b u=%b exp 0 0", s_overflow, s_underflow); end
    n_vec++; if (f_rvalid !== 1'b0 || f_load !== 3'd0) begin n_err++; $display("FAIL flush_fwft: got v=%b l=%0d exp v=0 l=0", f_rvalid, f_load); end
    wen = 1'b1; wdata = 8'h77; tick(); wen = 1'b0;
    ren = 1'b1; tick(); ren = 1'b0;
    n_vec++; if (s_rvalid !== 1'b1 || s_rdata !== 8'h77) begin n_err++; $display("FAIL flush_reuse: got v=%b d=%h exp v=1 d=77", s_rvalid, s_rdata); end
  endtask

  task automatic test_thresholds();
    logic exp_ae, exp_af;
    do_reset();
    for (int i = 0; i <= 4; i++) begin
      exp_ae = (i <= 1);
      exp_af = (i >= 3);
      n_vec++;
      if (s_load !== 3'(i) || s_aempty !== exp_ae || s_afull !== exp_af) begin
        n_err++; $display("FAIL thr_load%0d: got l=%0d ae=%b af=%b exp l=%0d ae=%b af=%b",
                          i, s_load, s_aempty, s_afull, i, exp_ae, exp_af);
      end
      if (i < 4) begin
        wen = 1'b1; wdata = 8'(i); tick(); wen = 1'b0;
      end
    end
    // Reset while full with requests pending: everything returns to reset state.
    rst = 1'b1; wen = 1'b1; ren = 1'b1; tick();
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    n_vec++;
    if (s_load !== 3'd0 || s_empty !== 1'b1 || s_full !== 1'b0 || s_aempty !== 1'b1 ||
        s_afull !== 1'b0 || s_rvalid !== 1'b0 || s_overflow !== 1'b0 || s_underflow !== 1'b0) begin
      n_err++; $display("FAIL thr_rst: got l=%0d e=%b f=%b ae=%b af=%b v=%b o=%b u=%b exp 0 1 0 1 0 0 0 0",
                        s_load, s_empty, s_full, s_aempty, s_afull, s_rvalid, s_overflow, s_underflow);
    end
    n_vec++; if (f_rvalid !== 1'b0 || f_load !== 3'd0) begin n_err++; $display("FAIL thr_rst_fwft: got v=%b l=%0d exp v=0 l=0", f_rvalid, f_load); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_std_fill_drain();
    test_std_underflow();
    test_fwft();
    test_wrap_w3();
    test_flush();
    test_thresholds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
